// File: rtl/booth_multiplier_top.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier: controller FSM + datapath.
// One multiply per assertion of go; done/p are registered and held until go drops.

module booth_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic last,
    output logic load,
    output logic step,
    output logic finish,
    output logic done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // go is deliberately ignored here: a started multiply always completes
                if (last) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    assign done = done_q;
endmodule

module booth_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   pin,
    output logic               last,
    output logic [2*WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH + 1);

    // A and M carry one extra bit so -2^(W-1) * -2^(W-1) does not overflow
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH:0]       a_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            m_q   <= m_d;
            a_q   <= a_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    always_comb begin
        m_d   = m_q;
        a_d   = a_q;
        q_d   = q_q;
        q1_d  = q1_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        unique case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
        if (load) begin
            m_d   = {ain[WIDTH-1], ain};
            a_d   = '0;
            q_d   = pin;
            q1_d  = 1'b0;
            cnt_d = CW'(WIDTH);
        end else if (step) begin
            a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
            q_d   = {a_sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q - 1'b1;
            if (finish) p_d = {a_d[WIDTH-1:0], q_d};
        end
    end

    assign last = (cnt_q == CW'(1));
    assign p    = p_q;
endmodule

module booth_multiplier_top #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   pin,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    logic load, step, finish, last;

    booth_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .last   (last),
        .load   (load),
        .step   (step),
        .finish (finish),
        .done   (done)
    );

    booth_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .finish (finish),
        .ain    (ain),
        .pin    (pin),
        .last   (last),
        .p      (p)
    );
endmodule

// File: tb/tb_booth_multiplier_top.sv
// Scoreboard bench for booth_multiplier_top: expected products queued at issue,
// popped on each rising edge of done.

module tb_booth_multiplier_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  ain;
    logic [7:0]  pin;
    logic        done;
    logic [15:0] p;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb[$];
    logic        done_prev = 1'b0;

    booth_multiplier_top #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .ain  (ain),
        .pin  (pin),
        .done (done),
        .p    (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // output monitor: every completion must match the oldest issued multiply
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
            else                chk("sb_p", 32'(p), 32'(sb.pop_front()));
        end
        done_prev <= done;
    end

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit chg);
        int          ai, bi, n;
        bit          got;
        logic [15:0] e;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e  = 16'(ai * bi);
        @(negedge clk);
        ain = a;
        pin = b;
        go  = 1'b1;
        sb.push_back(e);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) got = 1'b1;
            if (chg && n == 3) ain = ~ain;
        end
        chk("latency", 32'(n), 32'd9);
        chk("p_direct", 32'(p), 32'(e));
        // go still held: must stay in DONE without re-running
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_hold", 32'(done), 32'd1);
            chk("p_hold", 32'(p), 32'(e));
        end
        go = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_fall", 32'(done), 32'd0);
        chk("p_kept_idle", 32'(p), 32'(e));
    endtask

    initial begin
        rst = 1'b1;
        go  = 1'b1;
        ain = 8'd0;
        pin = 8'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_p", 32'(p), 32'd0);
        end
        go  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);

        run_mul(8'sd20, -8'sd10, 1'b0);     // 0xFF38
        run_mul(-8'sd10, -8'sd60, 1'b0);    // 0x0258
        run_mul(8'sd25, 8'sd40, 1'b0);      // 0x03E8
        run_mul(8'h80, 8'h80, 1'b0);        // 0x4000
        run_mul(8'h80, 8'h7F, 1'b0);        // 0xC080
        run_mul(8'h00, 8'hFF, 1'b0);        // 0x0000
        run_mul(8'h7F, 8'h7F, 1'b0);        // 0x3F01
        run_mul(8'sd13, -8'sd7, 1'b1);      // ain flipped mid-RUN, latched value used
        for (int i = 0; i < 6; i++)
            run_mul(8'($urandom), 8'($urandom), 1'b0);

        // reset during RUN step 4 aborts with no result
        @(negedge clk);
        ain = 8'sd50;
        pin = 8'sd3;
        go  = 1'b1;
        for (int i = 0; i < 4; i++) @(posedge clk);
        @(negedge clk);
        go  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_result", 32'(done), 32'd0);
        end
        chk("abort_p_after", 32'(p), 32'd0);

        run_mul(-8'sd3, 8'sd11, 1'b0);
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
